// File: rtl/quad_pkg.sv
// quad_pkg: shared types and helpers for the quadrature decoder.
//   qstate_t    - 2-bit encoder state {A,B}
//   step_e      - per-transition decode result
//   quad_decode - pure (prev,next) -> step_e Gray-code decoder
//   RES_X1/X4   - legal resolution settings
package quad_pkg;

  typedef logic [1:0] qstate_t;  // {A,B}

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_INC,
    STEP_DEC,
    STEP_ERR
  } step_e;

  localparam int RES_X1 = 1;
  localparam int RES_X4 = 4;

  // Forward (A leads B): 00->10->11->01->00. Reverse is the mirror.
  // Any transition flipping both bits at once is illegal.
  function automatic step_e quad_decode(input qstate_t prev, input qstate_t nxt);
    step_e r;
    r = STEP_NONE;
    case ({prev, nxt})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: r = STEP_INC;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: r = STEP_DEC;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: r = STEP_ERR;
      default:                                r = STEP_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_channel.sv
// quad_channel: one encoder channel.
//   Synchronises raw A/B, filters each on the shared sample tick, decodes
//   Gray-code transitions and keeps a wrapping/saturating signed count.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_tick        shared sample tick (one clk wide)
//   i_enc_a/b     raw asynchronous encoder inputs
//   i_clr         clear count and quarter accumulator
//   i_wrap        1: modulo count, 0: saturate at signed limits
//   i_err_clr     clear sticky error
//   o_cnt         signed position count
//   o_step        1-cycle pulse when o_cnt changes
//   o_dir         direction of last step (1 = up)
//   o_err         sticky illegal-transition flag
module quad_channel
  import quad_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int FILT  = 3,
  parameter int RES   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_tick,
  input  logic             i_enc_a,
  input  logic             i_enc_b,
  input  logic             i_clr,
  input  logic             i_wrap,
  input  logic             i_err_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_step,
  output logic             o_dir,
  output logic             o_err
);

  localparam int FW = (FILT < 2) ? 1 : $clog2(FILT + 1);
  localparam logic [FW-1:0]    FILT_M1 = FW'(FILT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};

  qstate_t              r_s1, r_s2;     // synchroniser stages
  qstate_t              r_filt;         // filtered {A,B}
  logic [1:0][FW-1:0]   r_fcnt;         // stability counters, [1]=A [0]=B
  logic                 r_init;         // first tick after reset seen
  step_e                r_evt;          // decoded transition, valid 1 cycle
  logic signed [2:0]    r_q;            // quarter accumulator, -3..+3
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_step, r_dir, r_err;

  qstate_t              w_filt_nxt;
  logic [1:0][FW-1:0]   w_fcnt_nxt;
  logic                 w_inc, w_dec;
  logic signed [2:0]    w_q_nxt;
  logic                 w_up_ok, w_dn_ok;

  // Filter: a level must disagree on FILT consecutive ticks to be accepted.
  always_comb begin
    w_filt_nxt = r_filt;
    w_fcnt_nxt = r_fcnt;
    for (int k = 0; k < 2; k++) begin
      if (r_s2[k] != r_filt[k]) begin
        if (r_fcnt[k] == FILT_M1) begin
          w_filt_nxt[k] = ~r_filt[k];
          w_fcnt_nxt[k] = '0;
        end else begin
          w_fcnt_nxt[k] = r_fcnt[k] + 1'b1;
        end
      end else begin
        w_fcnt_nxt[k] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_filt <= '0;
      r_fcnt <= '0;
      r_init <= 1'b0;
      r_evt  <= STEP_NONE;
    end else begin
      r_s1  <= {i_enc_a, i_enc_b};
      r_s2  <= r_s1;
      r_evt <= STEP_NONE;
      if (i_tick) begin
        r_init <= 1'b1;
        if (!r_init) begin
          // Adopt whatever the pins show without decoding: the encoder may
          // rest in any state, and that must not look like an edge.
          r_filt <= r_s2;
          r_fcnt <= '0;
        end else begin
          r_filt <= w_filt_nxt;
          r_fcnt <= w_fcnt_nxt;
          r_evt  <= quad_decode(r_filt, w_filt_nxt);
        end
      end
    end
  end

  // Resolution: x4 counts every edge; x1 needs four same-direction edges,
  // and opposite edges unwind the accumulator so jitter cancels out.
  always_comb begin
    w_inc   = 1'b0;
    w_dec   = 1'b0;
    w_q_nxt = r_q;
    if (RES == RES_X4) begin
      w_inc = (r_evt == STEP_INC);
      w_dec = (r_evt == STEP_DEC);
    end else begin
      if (r_evt == STEP_INC) begin
        if (r_q == 3'sd3) begin
          w_inc   = 1'b1;
          w_q_nxt = '0;
        end else begin
          w_q_nxt = r_q + 3'sd1;
        end
      end else if (r_evt == STEP_DEC) begin
        if (r_q == -3'sd3) begin
          w_dec   = 1'b1;
          w_q_nxt = '0;
        end else begin
          w_q_nxt = r_q - 3'sd1;
        end
      end
    end
  end

  assign w_up_ok = i_wrap || (r_cnt != CNT_MAX);
  assign w_dn_ok = i_wrap || (r_cnt != CNT_MIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      r_cnt  <= '0;
      r_step <= 1'b0;
      r_dir  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_step <= 1'b0;
      // A fresh illegal transition wins over a simultaneous clear.
      r_err  <= (r_err & ~i_err_clr) | (r_evt == STEP_ERR);
      if (i_clr) begin
        r_cnt <= '0;
        r_q   <= '0;
      end else begin
        r_q <= w_q_nxt;
        if (w_inc && w_up_ok) begin
          r_cnt  <= r_cnt + 1'b1;
          r_step <= 1'b1;
          r_dir  <= 1'b1;
        end else if (w_dec && w_dn_ok) begin
          r_cnt  <= r_cnt - 1'b1;
          r_step <= 1'b1;
          r_dir  <= 1'b0;
        end
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_step = r_step;
  assign o_dir  = r_dir;
  assign o_err  = r_err;

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: N_CH independent quadrature decoders sharing one sample tick.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   enc_a/b     raw encoder inputs, one bit per channel
//   clr         per-channel count/accumulator clear
//   wrap        1: counts wrap, 0: counts saturate
//   err_clr     per-channel sticky error clear
//   cnt         packed counts, channel i at [i*CNT_W +: CNT_W]
//   step/dir/err per-channel step pulse, last direction, sticky error
module quad_decoder
  import quad_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int CNT_W = 8,
  parameter int DIV   = 100_000,
  parameter int FILT  = 3,
  parameter int RES   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       enc_a,
  input  logic [N_CH-1:0]       enc_b,
  input  logic [N_CH-1:0]       clr,
  input  logic                  wrap,
  input  logic [N_CH-1:0]       err_clr,
  output logic [N_CH*CNT_W-1:0] cnt,
  output logic [N_CH-1:0]       step,
  output logic [N_CH-1:0]       dir,
  output logic [N_CH-1:0]       err
);

  localparam int DW      = $clog2(DIV);
  // Anything other than x1 decodes at full x4 resolution.
  localparam int RES_EFF = (RES == RES_X1) ? RES_X1 : RES_X4;

  logic [DW-1:0] r_div;
  logic          w_tick;

  assign w_tick = (r_div == DW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)         r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    quad_channel #(
      .CNT_W (CNT_W),
      .FILT  (FILT),
      .RES   (RES_EFF)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_tick    (w_tick),
      .i_enc_a   (enc_a[g]),
      .i_enc_b   (enc_b[g]),
      .i_clr     (clr[g]),
      .i_wrap    (wrap),
      .i_err_clr (err_clr[g]),
      .o_cnt     (cnt[g*CNT_W +: CNT_W]),
      .o_step    (step[g]),
      .o_dir     (dir[g]),
      .o_err     (err[g])
    );
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench: an x4 and an x1 decoder share the same stimulus.
module tb_quad_decoder;

  localparam int N_CH = 2, CNT_W = 8, DIV = 4, FILT = 3;

  logic clk = 1'b0;
  logic rst, wrap, mon_clr;
  logic [N_CH-1:0] enc_a, enc_b, clr, err_clr;
  logic [N_CH*CNT_W-1:0] cnt_x4, cnt_x1;
  logic [N_CH-1:0] step_x4, dir_x4, err_x4, step_x1, dir_x1, err_x1;

  int total = 0, bad = 0;
  int n_x4_0, n_x4_1, n_x1_0;
  logic [1:0] cur;

  always #5 clk = ~clk;

  quad_decoder #(.N_CH(N_CH), .CNT_W(CNT_W), .DIV(DIV), .FILT(FILT), .RES(4)) u_x4 (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .clr(clr), .wrap(wrap),
    .err_clr(err_clr), .cnt(cnt_x4), .step(step_x4), .dir(dir_x4), .err(err_x4));

  quad_decoder #(.N_CH(N_CH), .CNT_W(CNT_W), .DIV(DIV), .FILT(FILT), .RES(1)) u_x1 (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .clr(clr), .wrap(wrap),
    .err_clr(err_clr), .cnt(cnt_x1), .step(step_x1), .dir(dir_x1), .err(err_x1));

  // Step pulse counters.
  always @(posedge clk) begin
    if (mon_clr) begin
      n_x4_0 <= 0; n_x4_1 <= 0; n_x1_0 <= 0;
    end else begin
      n_x4_0 <= n_x4_0 + int'(step_x4[0]);
      n_x4_1 <= n_x4_1 + int'(step_x4[1]);
      n_x1_0 <= n_x1_0 + int'(step_x1[0]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mclr();
    mon_clr = 1'b1;
    wclk(1);
    mon_clr = 1'b0;
  endtask

  function automatic logic [1:0] fwd(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic drive(input logic [1:0] s);
    enc_a[0] = s[1];
    enc_b[0] = s[0];
    cur = s;
  endtask

  task automatic edge0(input bit up);
    drive(up ? fwd(cur) : rev(cur));
    wclk(16);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wclk(4);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wrap = 1'b1; mon_clr = 1'b1;
    enc_a = '0; enc_b = '0; clr = '0; err_clr = '0; cur = 2'b00;
    wclk(4);
    chk("rst_cnt",  32'(cnt_x4),  32'h0);
    chk("rst_step", 32'(step_x4), 32'h0);
    chk("rst_dir",  32'(dir_x4),  32'h0);
    chk("rst_err",  32'(err_x4),  32'h0);
    rst = 1'b0; mon_clr = 1'b0;
    wclk(20);

    // Full forward cycle on ch0.
    mclr();
    repeat (4) edge0(1'b1);
    wclk(4);
    chk("fwd_cnt",     32'(cnt_x4), 32'h0004);
    chk("fwd_steps0",  32'(n_x4_0), 32'd4);
    chk("fwd_steps1",  32'(n_x4_1), 32'd0);
    chk("fwd_dir",     32'(dir_x4), 32'h1);
    chk("fwd_x1_cnt",  32'(cnt_x1), 32'h0001);
    chk("fwd_x1_step", 32'(n_x1_0), 32'd1);

    // Glitch on A lasting two ticks.
    mclr();
    enc_a[0] = 1'b1; wclk(8);
    enc_a[0] = 1'b0; wclk(20);
    chk("glitch_cnt",   32'(cnt_x4), 32'h0004);
    chk("glitch_steps", 32'(n_x4_0), 32'd0);

    // Both bits flip together.
    mclr();
    drive(2'b11); wclk(16);
    chk("ill_err",    32'(err_x4), 32'h1);
    chk("ill_cnt",    32'(cnt_x4), 32'h0004);
    chk("ill_steps",  32'(n_x4_0), 32'd0);
    chk("ill_x1_err", 32'(err_x1), 32'h1);
    err_clr = 2'b01; wclk(1);
    err_clr = 2'b00;
    chk("errclr",     32'(err_x4), 32'h0);

    // Reset with a non-zero resting state: first tick must not decode.
    do_reset();
    wclk(20);
    chk("rst11_err", 32'(err_x4), 32'h0);
    chk("rst11_cnt", 32'(cnt_x4), 32'h0);

    // x1 partial cycles cancel.
    mclr();
    repeat (3) edge0(1'b1);
    repeat (3) edge0(1'b0);
    chk("x1_cancel_cnt",  32'(cnt_x1), 32'h0);
    chk("x1_cancel_step", 32'(n_x1_0), 32'd0);
    chk("x4_cancel_cnt",  32'(cnt_x4), 32'h0);
    chk("x4_cancel_step", 32'(n_x4_0), 32'd6);
    chk("x4_cancel_dir",  32'(dir_x4), 32'h0);
    repeat (4) edge0(1'b1);
    chk("x1_full_cnt",  32'(cnt_x1), 32'h0001);
    chk("x1_full_step", 32'(n_x1_0), 32'd1);
    chk("x4_full_cnt",  32'(cnt_x4), 32'h0004);

    // Climb to the positive limit, then wrap vs. saturate.
    repeat (123) edge0(1'b1);
    chk("at_max", 32'(cnt_x4), 32'h007f);
    mclr();
    edge0(1'b1);
    chk("wrap_cnt",  32'(cnt_x4), 32'h0080);
    chk("wrap_step", 32'(n_x4_0), 32'd1);
    edge0(1'b0);
    chk("unwrap_cnt", 32'(cnt_x4), 32'h007f);
    wrap = 1'b0;
    mclr();
    edge0(1'b1);
    chk("sat_cnt",  32'(cnt_x4), 32'h007f);
    chk("sat_step", 32'(n_x4_0), 32'd0);
    chk("sat_dir",  32'(dir_x4), 32'h0);

    // Clear held across an edge: step discarded, quarter accumulator reset.
    wrap = 1'b1;
    repeat (2) edge0(1'b1);
    chk("pre_clr_cnt", 32'(cnt_x4), 32'h0081);
    mclr();
    clr = 2'b01;
    edge0(1'b1);
    clr = 2'b00;
    chk("clr_cnt",     32'(cnt_x4), 32'h0);
    chk("clr_steps",   32'(n_x4_0), 32'd0);
    chk("clr_x1_cnt",  32'(cnt_x1), 32'h0);
    chk("clr_x1_step", 32'(n_x1_0), 32'd0);
    repeat (3) edge0(1'b1);
    chk("post_clr_x1_cnt", 32'(cnt_x1), 32'h0);
    chk("post_clr_x4_cnt", 32'(cnt_x4), 32'h0003);
    edge0(1'b1);
    chk("post_clr_x1_one", 32'(cnt_x1), 32'h0001);

    // Reset in the middle of filtering an edge.
    drive(fwd(cur));
    wclk(6);
    rst = 1'b1; wclk(3);
    chk("midrst_cnt",  32'(cnt_x4),  32'h0);
    chk("midrst_step", 32'(step_x4), 32'h0);
    chk("midrst_dir",  32'(dir_x4),  32'h0);
    chk("midrst_err",  32'(err_x4),  32'h0);
    rst = 1'b0;
    mclr();
    wclk(30);
    chk("midrst_post_err",   32'(err_x4), 32'h0);
    chk("midrst_post_cnt",   32'(cnt_x4), 32'h0);
    chk("midrst_post_steps", 32'(n_x4_0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
